snn_output_classifier: RTL
==========================

SNN_OUTPUT_CLASSIFIER -- requirements
Module: snn_output_classifier

Interface
REQ-001 Parameter NUM_OUTPUTS, default 4: number of output-neuron spike counts to scan; legal range 1..2^OUTPUT_SPIKE_ADDR_BITS.
REQ-002 Parameter OUTPUT_SPIKE_ADDR_BITS, default 4: width of the count-RAM address and of winner_idx.
REQ-003 Parameter COUNT_WIDTH, default 32: width of each spike count, winner_count and total_count.
REQ-004 S_AXI_ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 S_AXI_ARESETN  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  single-cycle request to classify; driven from the network-done event.
REQ-007 mem_addr  output  OUTPUT_SPIKE_ADDR_BITS  read address into the output spike-count RAM.
REQ-008 mem_rd_active  output  1  high while the block owns the RAM address port; the parent muxes mem_addr onto the RAM when this is high.
REQ-009 mem_data  input  COUNT_WIDTH  RAM read data, valid exactly one cycle after mem_addr is presented.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 result_valid  output  1  classification result available.
REQ-012 result_ready  input  1  consumer accepts the result.
REQ-013 winner_idx  output  OUTPUT_SPIKE_ADDR_BITS  index of the neuron with the highest count.
REQ-014 winner_count  output  COUNT_WIDTH  highest count.
REQ-015 total_count  output  COUNT_WIDTH  saturating sum of all counts.
REQ-016 tie  output  1  the maximum count is shared by two or more neurons.
REQ-017 no_spikes  output  1  all counts are zero.

Function
REQ-018 The FSM SHALL have four states: IDLE, SCAN, DRAIN and RESULT.
REQ-019 IDLE: start=1 SHALL move the FSM to SCAN on the next cycle; the address counter SHALL clear to 0; max, index, total, tie and no_spikes accumulators SHALL clear to 0.
REQ-020 SCAN: mem_addr SHALL equal the address counter; the counter SHALL advance by 1 per cycle; after the cycle presenting address NUM_OUTPUTS-1, the FSM SHALL move to DRAIN.
REQ-021 DRAIN: the FSM SHALL spend exactly one cycle here, consuming the last read datum, then move to RESULT.
REQ-022 mem_rd_active SHALL be 1 in SCAN and DRAIN and 0 otherwise; mem_addr SHALL be 0 when mem_rd_active=0.
REQ-023 Each datum arriving in the cycle after its address (during SCAN cycles 2..N and DRAIN) SHALL be compared and accumulated in that cycle (single-stage pipeline).
REQ-024 Compare rule for datum d at index i: if d > current max, then max<=d, idx<=i, tie<=0; else if d == current max and i != 0, then tie<=1. Index 0 SHALL always initialise max and idx. The lowest index therefore wins ties.
REQ-025 total SHALL accumulate d with saturation at 2^COUNT_WIDTH-1 and SHALL never wrap.
REQ-026 On entry to RESULT: no_spikes SHALL be (max==0); when no_spikes=1, tie SHALL read 0 and winner_idx SHALL read 0.
REQ-027 RESULT: result_valid SHALL be 1; all result outputs SHALL be held stable while result_ready=0; when result_valid & result_ready, the FSM SHALL return to IDLE on the next cycle.
REQ-028 Result outputs SHALL hold their last values in IDLE until the next start is accepted.
REQ-029 Latency: with start sampled at edge k, result_valid SHALL first be 1 after edge k+NUM_OUTPUTS+2.
REQ-030 start SHALL be ignored in SCAN, DRAIN and RESULT, including a start coincident with the result handshake.
REQ-031 With NUM_OUTPUTS=1, SCAN SHALL last one cycle, tie SHALL be 0, and winner_idx SHALL be 0.

Reset
REQ-032 With S_AXI_ARESETN=0 at a rising edge, the FSM SHALL go to IDLE and every output SHALL be 0 (mem_addr, mem_rd_active, busy, result_valid, winner_idx, winner_count, total_count, tie, no_spikes), including when reset occurs mid-SCAN or in RESULT.
REQ-033 After reset release, the first start SHALL produce a complete, uncorrupted scan.

Verification
REQ-034 Counts {3,9,2,9}, start pulse -> addresses 0,1,2,3 on consecutive cycles; result_valid 6 cycles after start; winner_idx=1, winner_count=9, tie=1, total_count=23, no_spikes=0.
REQ-035 Counts {0,0,0,0} -> no_spikes=1, tie=0, winner_idx=0, winner_count=0, total_count=0.
REQ-036 Counts {0xFFFFFFF0,0x20,5,0} -> winner_idx=0, winner_count=0xFFFFFFF0, total_count=0xFFFFFFFF (saturated), tie=0.
REQ-037 result_ready held low for 10 cycles in RESULT, with start pulsed during that window -> all outputs stable, no new scan; ready=1 -> IDLE next cycle, busy=0.
REQ-038 Reset asserted on the 2nd SCAN cycle -> all outputs 0 next cycle; a fresh start with {1,2,3,4} -> winner_idx=3, total_count=10.
REQ-039 Random counts, 1000 runs -> outputs match a reference argmax (lowest-index tie-break) and saturating sum.

Source files
------------

// File: rtl/snn_output_classifier.sv
// Scans the output-neuron spike-count RAM once per start pulse and reports the
// winning neuron (lowest index on ties), its count, a saturating total, and tie/no-spike flags.
module snn_output_classifier #(
   parameter int NUM_OUTPUTS            = 4,
   parameter int OUTPUT_SPIKE_ADDR_BITS = 4,
   parameter int COUNT_WIDTH            = 32
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic                              start,
   output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] mem_addr,
   output logic                              mem_rd_active,
   input  logic [COUNT_WIDTH-1:0]            mem_data,
   output logic                              busy,
   output logic                              result_valid,
   input  logic                              result_ready,
   output logic [OUTPUT_SPIKE_ADDR_BITS-1:0] winner_idx,
   output logic [COUNT_WIDTH-1:0]            winner_count,
   output logic [COUNT_WIDTH-1:0]            total_count,
   output logic                              tie,
   output logic                              no_spikes
);

   // Handshake: a result transfers on any rising edge where result_valid && result_ready;
   // result_valid never drops and the result fields never change until that transfer.

   localparam int AW = OUTPUT_SPIKE_ADDR_BITS;
   localparam int CW = COUNT_WIDTH;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OUTPUTS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q;
   logic            rd_vld_q;
   logic [AW-1:0]   rd_idx_q;
   logic [CW-1:0]   max_q, max_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            tie_q, tie_d;
   logic [CW-1:0]   total_q, total_d;
   logic [CW:0]     sum_w;
   logic            accept_start;
   logic            load_result;
   logic            handshake;

   logic            result_valid_q;
   logic [AW-1:0]   winner_idx_q;
   logic [CW-1:0]   winner_count_q;
   logic [CW-1:0]   total_count_q;
   logic            tie_out_q;
   logic            no_spikes_q;

   assign accept_start = (state_q == IDLE) && start;
   assign load_result  = (state_q == RESULT) && !result_valid_q;
   assign handshake    = (state_q == RESULT) && result_valid_q && result_ready;

   // State register
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) state_q <= IDLE;
      else                state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (addr_q == LAST_ADDR) state_d = DRAIN;
         DRAIN:   state_d = RESULT;
         RESULT:  if (handshake) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      mem_rd_active = (state_q == SCAN) || (state_q == DRAIN);
      mem_addr      = (state_q == SCAN) ? addr_q : '0;
      busy          = (state_q != IDLE);
      result_valid  = result_valid_q;
      winner_idx    = winner_idx_q;
      winner_count  = winner_count_q;
      total_count   = total_count_q;
      tie           = tie_out_q;
      no_spikes     = no_spikes_q;
   end

   // Compare/accumulate the datum returned for the address presented last cycle.
   always_comb begin
      max_d   = max_q;
      idx_d   = idx_q;
      tie_d   = tie_q;
      sum_w   = {1'b0, total_q} + {1'b0, mem_data};
      total_d = sum_w[CW] ? '1 : sum_w[CW-1:0];
      if (rd_idx_q == '0) begin
         max_d = mem_data;
         idx_d = '0;
         tie_d = 1'b0;
      end else if (mem_data > max_q) begin
         max_d = mem_data;
         idx_d = rd_idx_q;
         tie_d = 1'b0;
      end else if (mem_data == max_q) begin
         tie_d = 1'b1;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         addr_q   <= '0;
         rd_vld_q <= 1'b0;
         rd_idx_q <= '0;
         max_q    <= '0;
         idx_q    <= '0;
         tie_q    <= 1'b0;
         total_q  <= '0;
      end else begin
         rd_vld_q <= (state_q == SCAN);
         rd_idx_q <= addr_q;
         if (accept_start) begin
            addr_q  <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            tie_q   <= 1'b0;
            total_q <= '0;
         end else begin
            if (state_q == SCAN && addr_q != LAST_ADDR) addr_q <= addr_q + AW'(1);
            if (rd_vld_q) begin
               max_q   <= max_d;
               idx_q   <= idx_d;
               tie_q   <= tie_d;
               total_q <= total_d;
            end
         end
      end
   end

   // Result registers capture the finished accumulators once, then hold until the next capture.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         result_valid_q <= 1'b0;
         winner_idx_q   <= '0;
         winner_count_q <= '0;
         total_count_q  <= '0;
         tie_out_q      <= 1'b0;
         no_spikes_q    <= 1'b0;
      end else if (load_result) begin
         result_valid_q <= 1'b1;
         no_spikes_q    <= (max_q == '0);
         tie_out_q      <= tie_q && (max_q != '0);
         winner_idx_q   <= (max_q == '0) ? '0 : idx_q;
         winner_count_q <= max_q;
         total_count_q  <= total_q;
      end else if (handshake) begin
         result_valid_q <= 1'b0;
      end
   end

endmodule
